// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, word width and the memory-port arbiter state encoding.
package y86_pkg;

  localparam int unsigned WORD_W = 64;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StIssueIf,
    StIssueDm,
    StDone
  } arb_state_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable down-counter that flags an expired memory access; only built with MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog #(
  parameter int unsigned Cycles = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Loaded with Cycles-1 so the flag rises in the Cycles-th counted cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(Cycles - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory between fetch and memory stages (data has priority,
// bounded by a starvation streak). Define MEM_ARB_TIMEOUT_EN to add the no-ack watchdog.
module mem_port_arbiter
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W        = 64,
  parameter int unsigned MEM_WORDS     = 1024,
  parameter int unsigned DM_STREAK_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC   = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [WORD_W-1:0] if_rdata,
  output logic [2:0]        if_stat,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [WORD_W-1:0] dm_rdata,
  output logic [2:0]        dm_stat,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned StreakW = $clog2(DM_STREAK_MAX + 1);
  localparam logic [ADDR_W-1:0] AddrLimit = ADDR_W'(MEM_WORDS) << 3;

  arb_state_e          state_q, state_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
  logic [WORD_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic [2:0]          if_stat_q, if_stat_d;
  logic [2:0]          dm_stat_q, dm_stat_d;

  logic                grant_dm, grant_if, streak_at_max;
  logic [ADDR_W-1:0]   req_addr;
  logic                fin, fin_dm;
  logic [WORD_W-1:0]   fin_rdata;
  logic [2:0]          fin_stat;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_load, wd_expired;

  mem_arb_watchdog #(
    .Cycles (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (wd_load),
    .en_i      ((state_q == StIssueIf) || (state_q == StIssueDm)),
    .expired_o (wd_expired)
  );
`endif

  assign streak_at_max = (streak_q == StreakW'(DM_STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_stat_d   = if_stat_q;
    dm_stat_d   = dm_stat_q;
    grant_dm    = 1'b0;
    grant_if    = 1'b0;
    req_addr    = '0;
    fin         = 1'b0;
    fin_dm      = 1'b0;
    fin_rdata   = '0;
    fin_stat    = STAT_AOK;
`ifdef MEM_ARB_TIMEOUT_EN
    wd_load     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        grant_dm = dm_req && !(if_req && streak_at_max);
        grant_if = if_req && !grant_dm;
        req_addr = grant_dm ? dm_addr : if_addr;
        // The streak only counts data grants that made fetch wait.
        if (grant_dm && if_req) begin
          streak_d = streak_at_max ? streak_q : streak_q + 1'b1;
        end else begin
          streak_d = '0;
        end
        if (grant_dm || grant_if) begin
          if (req_addr >= AddrLimit) begin
            fin      = 1'b1;
            fin_dm   = grant_dm;
            fin_stat = STAT_ADR;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = grant_dm && dm_we;
            mem_addr_d  = req_addr;
            mem_wdata_d = grant_dm ? dm_wdata : '0;
            state_d     = grant_dm ? StIssueDm : StIssueIf;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_load     = 1'b1;
`endif
          end
        end
      end
      StIssueIf, StIssueDm: begin
        if (mem_ack) begin
          fin       = 1'b1;
          fin_dm    = (state_q == StIssueDm);
          fin_rdata = mem_we_q ? '0 : mem_rdata;
          fin_stat  = STAT_AOK;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (wd_expired) begin
          fin      = 1'b1;
          fin_dm   = (state_q == StIssueDm);
          fin_stat = STAT_ADR;
`endif
        end
        if (fin) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fin) begin
      state_d = StDone;
      if (fin_dm) begin
        dm_done_d  = 1'b1;
        dm_rdata_d = fin_rdata;
        dm_stat_d  = fin_stat;
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = fin_rdata;
        if_stat_d  = fin_stat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_stat_q   <= '0;
      dm_stat_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_stat_q   <= if_stat_d;
      dm_stat_q   <= dm_stat_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign if_stat   = if_stat_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_stat   = dm_stat_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected completions, a monitor
// pops and compares on every done pulse, and a memory responder models ack latency.
module tb_mem_port_arbiter;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_done;
  logic [63:0] if_rdata;
  logic [2:0]  if_stat;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [63:0] dm_addr = '0;
  logic [63:0] dm_wdata = '0;
  logic        dm_done;
  logic [63:0] dm_rdata;
  logic [2:0]  dm_stat;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .if_stat   (if_stat),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .dm_stat   (dm_stat),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct packed {
    logic        is_dm;
    logic [63:0] rdata;
    logic [2:0]  stat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   failed = 0;

  // Memory responder knobs and observation counters.
  logic ack_en = 1'b1;
  logic stray = 1'b0;
  int   ack_wait = 0;
  int   wcnt = 0;
  int   req_cycles = 0;
  int   we_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] rd_val(input logic [63:0] a);
    return (a == 64'h40) ? 64'hDEAD_BEEF : {32'hC0DE_0000, a[31:0]};
  endfunction

  function automatic exp_t mk(input logic is_dm, input logic [63:0] rdata, input logic [2:0] stat);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = rdata;
    e.stat  = stat;
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        if (mem_we && (mem_wdata == 64'h1234)) we_cycles++;
        if (ack_en && (wcnt == ack_wait)) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_val(mem_addr);
          wcnt      = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = '0;
          wcnt++;
        end
      end else begin
        mem_ack   = stray;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        wcnt      = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (if_done || dm_done) begin
        check("single_done", {63'b0, if_done & dm_done}, 64'd0);
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_done: got if_done=%b dm_done=%b, required no done", if_done,
                   dm_done);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_port_is_dm", {63'b0, dm_done}, {63'b0, mon_e.is_dm});
          check("done_rdata", dm_done ? dm_rdata : if_rdata, mon_e.rdata);
          check("done_stat", {61'b0, dm_done ? dm_stat : if_stat}, {61'b0, mon_e.stat});
        end
      end
    end
  end

  // Issues one access and counts negedges until its done pulse.
  task automatic access(input logic is_dm, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input int wait_n, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    @(negedge clk);
    ack_wait = wait_n;
    if (is_dm) begin
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = addr;
      dm_wdata = wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
    end
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if ((is_dm && dm_done) || (!is_dm && if_done)) seen = 1'b1;
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    if (!seen) begin
      tests++;
      failed++;
      $display("FAIL access_timeout: got no done within 300 cycles, required a done pulse");
    end
  endtask

  int lat;
  int dm_left;
  int if_left;
  int cyc;

  initial begin
    #1 rst = 1'b1;
    #12;
    check("rst_mem_req", {63'b0, mem_req}, 64'd0);
    check("rst_mem_we", {63'b0, mem_we}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_dones", {62'b0, if_done, dm_done}, 64'd0);
    check("rst_rdata", if_rdata | dm_rdata, 64'd0);
    check("rst_stat", {58'b0, if_stat, dm_stat}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Stray acks while idle must not produce a completion.
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_no_req", {63'b0, mem_req}, 64'd0);

    exp_q.push_back(mk(1'b1, 64'hDEAD_BEEF, STAT_AOK));
    access(1'b1, 1'b0, 64'h40, '0, 0, lat);
    check("zero_wait_latency", 64'(lat), 64'd2);

    req_cycles = 0;
    we_cycles  = 0;
    exp_q.push_back(mk(1'b1, 64'd0, STAT_AOK));
    access(1'b1, 1'b1, 64'h8, 64'h1234, 3, lat);
    check("write_latency", 64'(lat), 64'd5);
    check("write_req_cycles", 64'(req_cycles), 64'd4);
    check("write_we_data_cycles", 64'(we_cycles), 64'd4);

    exp_q.push_back(mk(1'b0, 64'hC0DE_0000_0000_1FF8, STAT_AOK));
    access(1'b0, 1'b0, 64'h1FF8, '0, 1, lat);
    check("last_word_latency", 64'(lat), 64'd3);

    req_cycles = 0;
    exp_q.push_back(mk(1'b0, 64'd0, STAT_ADR));
    access(1'b0, 1'b0, 64'h2000, '0, 0, lat);
    check("if_oob_latency", 64'(lat), 64'd1);
    check("if_oob_no_mem_req", 64'(req_cycles), 64'd0);

    req_cycles = 0;
    exp_q.push_back(mk(1'b1, 64'd0, STAT_ADR));
    access(1'b1, 1'b1, 64'hFFFF_0000_0000_0000, 64'h55, 0, lat);
    check("dm_oob_latency", 64'(lat), 64'd1);
    check("dm_oob_no_mem_req", 64'(req_cycles), 64'd0);

    // Contention: 4 data grants, then fetch, then the remaining data, then fetch.
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 64'hC0DE_0000_0000_0100, STAT_AOK));
    exp_q.push_back(mk(1'b0, 64'hC0DE_0000_0000_0200, STAT_AOK));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(1'b1, 64'hC0DE_0000_0000_0100, STAT_AOK));
    exp_q.push_back(mk(1'b0, 64'hC0DE_0000_0000_0200, STAT_AOK));
    @(negedge clk);
    ack_wait = 1;
    dm_left  = 6;
    if_left  = 2;
    dm_we    = 1'b0;
    dm_addr  = 64'h100;
    if_addr  = 64'h200;
    dm_req   = 1'b1;
    if_req   = 1'b1;
    cyc      = 0;
    for (int i = 0; i < 200 && (dm_left + if_left) > 0; i++) begin
      @(negedge clk);
      cyc++;
      if (dm_done) dm_left--;
      if (if_done) if_left--;
      if (dm_left == 0) dm_req = 1'b0;
      if (if_left == 0) if_req = 1'b0;
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    check("contention_remaining", 64'(dm_left + if_left), 64'd0);
    check("contention_cycles", 64'(cyc), 64'd31);

    // Reset in the middle of a write access.
    ack_en = 1'b0;
    @(negedge clk);
    dm_we    = 1'b1;
    dm_addr  = 64'h300;
    dm_wdata = 64'h1234;
    dm_req   = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_mem_req", {63'b0, mem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_req", {63'b0, mem_req}, 64'd0);
    check("midrst_mem_we", {63'b0, mem_we}, 64'd0);
    check("midrst_mem_wdata", mem_wdata, 64'd0);
    check("midrst_dones", {62'b0, if_done, dm_done}, 64'd0);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    ack_en = 1'b1;
    exp_q.push_back(mk(1'b1, 64'hC0DE_0000_0000_0308, STAT_AOK));
    access(1'b1, 1'b0, 64'h308, '0, 0, lat);
    check("post_rst_latency", 64'(lat), 64'd2);

`ifdef MEM_ARB_TIMEOUT_EN
    ack_en     = 1'b0;
    req_cycles = 0;
    exp_q.push_back(mk(1'b1, 64'd0, STAT_ADR));
    access(1'b1, 1'b0, 64'h48, '0, 0, lat);
    check("timeout_req_cycles", 64'(req_cycles), 64'd64);
    check("timeout_latency", 64'(lat), 64'd65);
    ack_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
